// File: rtl/dmem_host_arbiter_if.sv
// dmem_host_arbiter_if: host channel bundle (request/grant/ack with packed per-host commands).
interface dmem_host_arbiter_if #(
    parameter int NUM_HOST = 2,
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32
);
    logic [NUM_HOST-1:0]        req;
    logic [NUM_HOST-1:0]        we;
    logic [NUM_HOST*ADDR_W-1:0] addr;
    logic [NUM_HOST*DATA_W-1:0] wdata;
    logic [NUM_HOST-1:0]        gnt;
    logic [NUM_HOST-1:0]        ack;
    logic [DATA_W-1:0]          rdata;
    modport master (output req, we, addr, wdata, input gnt, ack, rdata);
    modport slave  (input req, we, addr, wdata, output gnt, ack, rdata);
endinterface

// File: rtl/dmem_host_arbiter.sv
// dmem_host_arbiter: shares data_mem between the core and round-robin host channels,
// stalling the core for one cycle when a host has waited STARVE_MAX cycles.
module dmem_host_arbiter #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 32,
    parameter int NUM_HOST   = 2,
    parameter int STARVE_MAX = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_run,
    input  logic              cpu_mem_en,
    input  logic              cpu_we,
    input  logic [2:0]        cpu_funct3,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_stall,
    dmem_host_arbiter_if.slave host,
    output logic              mem_we,
    output logic [2:0]        mem_funct3,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);
    localparam int PW = NUM_HOST > 1 ? $clog2(NUM_HOST) : 1;
    localparam int CW = STARVE_MAX > 0 ? $clog2(STARVE_MAX + 1) : 1;
    logic [PW-1:0] ptr, sel, nxt;
    logic [CW-1:0] starve;
    logic          core_slot, host_slot;
    // First requester at or after the pointer; ptr+k never exceeds 2*NUM_HOST-2, so one wrap suffices.
    always_comb begin
        logic          found;
        logic [PW:0]   sum;
        logic [PW-1:0] idx;
        found = 1'b0;
        sel   = '0;
        for (int k = 0; k < NUM_HOST; k++) begin
            sum = {1'b0, ptr} + (PW+1)'(k);
            idx = sum >= (PW+1)'(NUM_HOST) ? PW'(sum - (PW+1)'(NUM_HOST)) : PW'(sum);
            if (!found && host.req[idx]) begin
                found = 1'b1;
                sel   = idx;
            end
        end
    end
    assign nxt        = sel == PW'(NUM_HOST - 1) ? '0 : sel + 1'b1;
    assign core_slot  = cpu_run & cpu_mem_en & ~cpu_stall;
    assign host_slot  = rst & ~core_slot & (|host.req);
    assign host.gnt   = host_slot ? NUM_HOST'(1) << sel : '0;
    assign mem_we     = rst & (core_slot ? cpu_we : host_slot & host.we[sel]);
    assign mem_funct3 = host_slot ? 3'b010 : cpu_funct3;
    assign mem_addr   = host_slot ? host.addr[sel*ADDR_W +: ADDR_W] : cpu_addr;
    assign mem_wdata  = host_slot ? host.wdata[sel*DATA_W +: DATA_W] : cpu_wdata;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr        <= '0;
            starve     <= '0;
            cpu_stall  <= 1'b0;
            host.ack   <= '0;
            host.rdata <= '0;
        end else begin
            host.ack  <= host.gnt;
            cpu_stall <= 1'b0;
            if (host_slot) ptr <= nxt;
            if (host_slot && !host.we[sel]) host.rdata <= mem_rdata;
            if (!cpu_run || host_slot) starve <= '0;
            else if (|host.req) begin
                if (STARVE_MAX != 0 && starve == CW'(STARVE_MAX - 1)) begin
                    starve    <= '0;
                    cpu_stall <= 1'b1;
                end else if (starve != '1) starve <= starve + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_dmem_host_arbiter.sv
// tb_dmem_host_arbiter: randomized host/core traffic against a reference model,
// with acks and read data checked by a scoreboard monitor.
module tb_dmem_host_arbiter;
    localparam int NH = 4;
    localparam int SM = 15;
    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_run, cpu_mem_en, cpu_we, cpu_stall, mem_we;
    logic [2:0]  cpu_funct3, mem_funct3;
    logic [31:0] cpu_addr, cpu_wdata, mem_addr, mem_wdata, mem_rdata;
    always #5 clk = ~clk;
    dmem_host_arbiter_if #(.NUM_HOST(NH), .ADDR_W(32), .DATA_W(32)) host ();
    dmem_host_arbiter #(.DATA_W(32), .ADDR_W(32), .NUM_HOST(NH), .STARVE_MAX(SM)) dut (
        .clk(clk), .rst(rst), .cpu_run(cpu_run), .cpu_mem_en(cpu_mem_en), .cpu_we(cpu_we),
        .cpu_funct3(cpu_funct3), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_stall(cpu_stall),
        .host(host), .mem_we(mem_we), .mem_funct3(mem_funct3), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );
    // Bench-side data memory, cleared while in reset
    logic [31:0] tmem [16];
    assign mem_rdata = tmem[mem_addr[3:0]];
    always @(posedge clk) begin
        if (!rst) for (int i = 0; i < 16; i++) tmem[i] <= '0;
        else if (mem_we) tmem[mem_addr[3:0]] <= mem_wdata;
    end
    typedef struct {int h; logic [31:0] rd; int cyc;} exp_t;
    exp_t        sbq[$];
    exp_t        e;
    int          checks = 0, errors = 0, cyc = 0;
    bit          pend[NH], hwe[NH];
    logic [31:0] haddr[NH], hwd[NH];
    int          m_ptr, m_cnt;
    bit          m_stall;
    logic [31:0] ref_mem[16];
    logic [31:0] m_rd;
    always @(posedge clk) cyc <= cyc + 1;
    task automatic chk(input string n, input logic [63:0] a, input logic [63:0] x);
        checks++;
        if (a !== x) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", n, a, x, cyc);
        end
    endtask
    always @(negedge clk) begin
        if (rst && host.ack != 0) begin
            if (sbq.size() == 0) chk("ack_unexpected", 64'(host.ack), 64'd0);
            else begin
                e = sbq.pop_front();
                chk("ack_onehot", 64'(host.ack), 64'(1) << e.h);
                chk("ack_cycle", 64'(cyc), 64'(e.cyc));
                chk("ack_rdata", 64'(host.rdata), 64'(e.rd));
            end
        end
    end
    task automatic model_reset();
        m_ptr = 0; m_cnt = 0; m_stall = 0; m_rd = '0;
        for (int i = 0; i < 16; i++) ref_mem[i] = '0;
        for (int i = 0; i < NH; i++) pend[i] = 0;
    endtask
    task automatic drive();
        for (int i = 0; i < NH; i++) begin
            host.req[i] = pend[i];
            host.we[i]  = hwe[i];
            host.addr[i*32 +: 32]  = haddr[i];
            host.wdata[i*32 +: 32] = hwd[i];
        end
    endtask
    // Spec-level reference: who owns the port this cycle, what memory holds, when the core must stall
    task automatic model();
        bit          core, any, we_x, nstall;
        int          g;
        logic [31:0] a_x, d_x;
        core = cpu_run && cpu_mem_en && !m_stall;
        any = 0;
        g = -1;
        for (int i = 0; i < NH; i++) any |= pend[i];
        if (!core) for (int k = 0; k < NH; k++) if (g < 0 && pend[(m_ptr + k) % NH]) g = (m_ptr + k) % NH;
        we_x = core ? cpu_we : (g >= 0 ? hwe[g] : 1'b0);
        a_x = g >= 0 ? haddr[g] : cpu_addr;
        d_x = g >= 0 ? hwd[g] : cpu_wdata;
        chk("gnt", 64'(host.gnt), g >= 0 ? 64'(1) << g : 64'd0);
        chk("cpu_stall", 64'(cpu_stall), 64'(m_stall));
        chk("mem_we", 64'(mem_we), 64'(we_x));
        chk("mem_addr", 64'(mem_addr), 64'(a_x));
        chk("mem_wdata", 64'(mem_wdata), 64'(d_x));
        chk("mem_funct3", 64'(mem_funct3), g >= 0 ? 64'd2 : 64'(cpu_funct3));
        if (g >= 0) begin
            if (!hwe[g]) m_rd = ref_mem[haddr[g][3:0]];
            sbq.push_back('{g, m_rd, cyc + 1});
            pend[g] = 0;
            m_ptr = (g + 1) % NH;
        end
        if (we_x) ref_mem[a_x[3:0]] = d_x;
        nstall = 0;
        if (!cpu_run || g >= 0) m_cnt = 0;
        else if (any) begin
            m_cnt++;
            if (m_cnt == SM) begin
                nstall = 1;
                m_cnt = 0;
            end
        end
        m_stall = nstall;
    endtask
    // en: 0 random, 1 always, 2 alternating, 3 never
    task automatic step(input bit run, input int en, input bit rnd);
        @(posedge clk);
        #1;
        cpu_run    = run;
        cpu_mem_en = en == 0 ? 1'($urandom_range(0, 1)) : en == 1 ? 1'b1 : en == 2 ? 1'(cyc % 2) : 1'b0;
        cpu_we     = 1'($urandom_range(0, 1));
        cpu_funct3 = 3'($urandom_range(0, 7));
        cpu_addr   = $urandom_range(0, 15);
        cpu_wdata  = $urandom;
        if (rnd) for (int i = 0; i < NH; i++) if (!pend[i] && $urandom_range(0, 99) < 40) begin
            pend[i]  = 1;
            hwe[i]   = 1'($urandom_range(0, 1));
            haddr[i] = $urandom_range(0, 15);
            hwd[i]   = $urandom;
        end
        drive();
        @(negedge clk);
        model();
    endtask
    task automatic set_host(input int i, input bit we, input int a, input logic [31:0] d);
        pend[i] = 1; hwe[i] = we; haddr[i] = a; hwd[i] = d;
    endtask
    initial begin
        bit r;
        for (int i = 0; i < NH; i++) begin haddr[i] = '0; hwd[i] = '0; hwe[i] = 0; end
        model_reset();
        rst = 1'b0;
        cpu_run = 1; cpu_mem_en = 1; cpu_we = 1; cpu_funct3 = 0; cpu_addr = 0; cpu_wdata = 0;
        host.req = '1; host.we = '1; host.addr = '0; host.wdata = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_gnt", 64'(host.gnt), 64'd0);
        chk("rst_mem_we", 64'(mem_we), 64'd0);
        chk("rst_ack", 64'(host.ack), 64'd0);
        chk("rst_rdata", 64'(host.rdata), 64'd0);
        chk("rst_stall", 64'(cpu_stall), 64'd0);
        host.req = '0; cpu_mem_en = 0;
        rst = 1'b1;
        // Directed write-then-read by host0 with the core halted
        set_host(0, 1, 4, 32'hDEADBEEF);
        step(0, 3, 0);
        set_host(0, 0, 4, 32'h0);
        step(0, 3, 0);
        step(0, 3, 0);
        for (int i = 0; i < 300; i++) step(0, 0, 1);
        for (int i = 0; i < 300; i++) step(1, 0, 1);
        for (int i = 0; i < 300; i++) step(1, 1, 1);
        for (int i = 0; i < 200; i++) step(1, 2, 1);
        r = 1;
        for (int i = 0; i < 400; i++) begin
            if (i % 8 == 0) r = 1'($urandom_range(0, 1));
            step(r, 0, 1);
        end
        for (int i = 0; i < 10; i++) step(0, 3, 0);
        // Reset while host1 is re-granted with its previous ack still high
        set_host(1, 0, 5, 32'h0);
        step(0, 3, 0);
        set_host(1, 0, 6, 32'h0);
        @(posedge clk);
        #1;
        drive();
        #1;
        chk("pre_rst_gnt", 64'(host.gnt), 64'd2);
        chk("pre_rst_ack", 64'(host.ack), 64'd2);
        rst = 1'b0;
        #1;
        chk("mid_rst_gnt", 64'(host.gnt), 64'd0);
        chk("mid_rst_ack", 64'(host.ack), 64'd0);
        chk("mid_rst_rdata", 64'(host.rdata), 64'd0);
        chk("mid_rst_stall", 64'(cpu_stall), 64'd0);
        chk("mid_rst_mem_we", 64'(mem_we), 64'd0);
        sbq.delete();
        model_reset();
        drive();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        // Pointer restarts at host0, then wrap-around from pointer 2 to host3 before host1
        set_host(0, 0, 1, 32'h0);
        set_host(1, 0, 2, 32'h0);
        step(0, 3, 0);
        step(0, 3, 0);
        set_host(1, 0, 3, 32'h0);
        set_host(3, 0, 4, 32'h0);
        step(0, 3, 0);
        step(0, 3, 0);
        for (int i = 0; i < 300; i++) step(1, 0, 1);
        for (int i = 0; i < 12; i++) step(0, 3, 0);
        chk("sb_drain", 64'(sbq.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
